// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding, default word length and the four
// CPOL/CPHA mode codes, used by the slave RTL and by the master-side bench.
package spi_pkg;

  localparam int SPI_DATA_W = 16;

  // Mode code is {CPOL, CPHA}.
  localparam logic [1:0] SPI_MODE_0 = 2'b00;
  localparam logic [1:0] SPI_MODE_1 = 2'b01;
  localparam logic [1:0] SPI_MODE_2 = 2'b10;
  localparam logic [1:0] SPI_MODE_3 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } spi_state_e;

  typedef struct packed {
    spi_state_e state;
    logic       ss_s;
    logic       sclk_s;
  } spi_dbg_t;

  // Data is sampled on the rising sclk edge when CPOL equals CPHA.
  function automatic logic spi_sample_rise(input logic cpol, input logic cpha);
    logic [1:0] mode;
    mode = {cpol, cpha};
    case (mode)
      SPI_MODE_0, SPI_MODE_3: spi_sample_rise = 1'b1;
      SPI_MODE_1, SPI_MODE_2: spi_sample_rise = 1'b0;
      default:                spi_sample_rise = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for a small bus of asynchronous inputs; bit 0 also gets
// single-cycle rise/fall pulses derived from its synchronized level.
module spi_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         rise,
  output logic         fall
);

  logic [W-1:0] meta;
  logic         prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= '0;
      dout <= '0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      dout <= meta;
      prev <= dout[0];
    end
  end

  assign rise = dout[0] & ~prev;
  assign fall = ~dout[0] & prev;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, oversampled by clk: one DATA_W-bit word per selection, MSB first,
// with a one-word tx holding register and single-cycle status pulses.
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_W       = SPI_DATA_W,
  parameter int CLK_POLARITY = 0,
  parameter int CLK_PHASE    = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              tx_underrun,
  output logic              abort,
  output spi_dbg_t          dbg
);

  localparam int CNT_W       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam bit SAMPLE_RISE = spi_sample_rise(1'(CLK_POLARITY), 1'(CLK_PHASE));
  localparam bit PHASE1      = (CLK_PHASE != 0);

  logic [2:0]        sync_q;
  logic              sclk_s, ss_s, mosi_s;
  logic              sclk_rise, sclk_fall;
  logic              sample_ev, shift_ev;
  logic              ss_q, ss_fall, start;
  spi_state_e        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] hold, tx_sr, rx_sr, rx_next, load_word;
  logic              hold_valid;

  spi_sync_edge #(.W(3)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({mosi, ss, sclk}),
    .dout  (sync_q),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  assign sclk_s = sync_q[0];
  assign ss_s   = sync_q[1];
  assign mosi_s = sync_q[2];

  assign sample_ev = SAMPLE_RISE ? sclk_rise : sclk_fall;
  assign shift_ev  = SAMPLE_RISE ? sclk_fall : sclk_rise;

  // ss_q resets low, so a select held through reset must be seen high first.
  assign ss_fall   = ss_q & ~ss_s;
  assign start     = (state == ST_IDLE) && ss_fall;
  assign load_word = hold_valid ? hold : '0;
  assign rx_next   = {rx_sr[DATA_W-2:0], mosi_s};

  // tx handshake: a word is taken on a clk edge where tx_valid and tx_ready are
  // both high. tx_ready is high while the holding register is empty, and also
  // during the load cycle, when the old word leaves for the shift register.
  assign tx_ready = ~hold_valid | start;

  assign dbg = '{state: state, ss_s: ss_s, sclk_s: sclk_s};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      ss_q        <= 1'b0;
      bit_cnt     <= '0;
      hold        <= '0;
      hold_valid  <= 1'b0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      abort       <= 1'b0;
      miso        <= 1'b0;
      miso_oe     <= 1'b0;
    end else begin
      ss_q        <= ss_s;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      abort       <= 1'b0;

      if (tx_valid && tx_ready) begin
        hold       <= tx_data;
        hold_valid <= 1'b1;
      end else if (start) begin
        hold_valid <= 1'b0;
      end

      if (ss_s) begin
        if (state == ST_ACTIVE) abort <= 1'b1;
        state   <= ST_IDLE;
        bit_cnt <= '0;
        tx_sr   <= '0;
        rx_sr   <= '0;
        miso    <= 1'b0;
        miso_oe <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (ss_fall) begin
              state       <= ST_ACTIVE;
              miso_oe     <= 1'b1;
              bit_cnt     <= '0;
              rx_sr       <= '0;
              tx_underrun <= ~hold_valid;
              // With CPHA=0 the MSB must be on the wire before the first edge.
              if (PHASE1) begin
                miso  <= 1'b0;
                tx_sr <= load_word;
              end else begin
                miso  <= load_word[DATA_W-1];
                tx_sr <= load_word << 1;
              end
            end
          end
          ST_ACTIVE: begin
            if (shift_ev) begin
              miso  <= tx_sr[DATA_W-1];
              tx_sr <= tx_sr << 1;
            end
            if (sample_ev) begin
              rx_sr <= rx_next;
              if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                rx_data  <= rx_next;
                rx_valid <= 1'b1;
                bit_cnt  <= '0;
                state    <= ST_DONE;
              end else begin
                bit_cnt <= bit_cnt + CNT_W'(1);
              end
            end
          end
          ST_DONE: begin
            state <= ST_DONE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
